// File: rtl/ahb_lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_pkg
//
// Shared AHB-Lite definitions for the memory slave front end and anything
// that drives it.
//
//   htrans_t        transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   HSIZE_WORD      HSIZE encoding of a 32-bit transfer
//   HRESP_OKAY/...  response encodings
//   slave_state_t   data-phase state of the slave FSM
//   is_active_trans true for transfer types that start a data phase
// ---------------------------------------------------------------------------
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,  // no data phase in progress
    S_WAIT = 3'd1,  // data phase, wait counter still running
    S_LAST = 3'd2,  // final data-phase cycle
    S_ERR1 = 3'd3,  // first ERROR cycle (not ready)
    S_ERR2 = 3'd4   // second ERROR cycle (ready)
  } slave_state_t;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic is_active_trans(input htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_mem_slave
//
// AHB-Lite slave front end for the on-chip word memory. Accepts address
// phases, stretches the data phase by WAIT_STATES cycles and turns each
// transfer into word-indexed read/write strobes for external_memory.
// HRDATA/HWDATA do not pass through this block; it only sequences them.
//
// Parameters
//   WAIT_STATES  data-phase wait cycles per OKAY transfer (0..7)
//   MEM_WORDS    memory depth in 32-bit words
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,  AHB-Lite address phase from the master
//   HWRITE, HSIZE, HREADY
//   HREADYOUT, HRESP      this slave's data-phase response
//   READ_addr, read_flag  word index / enable for memory reads
//   WRITE_addr, write_flag word index / enable for memory writes
//
// Build option
//   ERR_RESP_EN  when defined, out-of-range, misaligned or non-word
//                transfers get a two-cycle ERROR response instead of
//                wrapping into the memory.
//
// Every output comes straight from a flop: the next-state logic computes
// the output values for the following cycle and they are registered
// together with the state.
// ---------------------------------------------------------------------------
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MEM_WORDS   = 4096
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] READ_addr,
  output logic        read_flag,
  output logic [31:0] WRITE_addr,
  output logic        write_flag
);

  localparam int          IDX_BITS = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] IDX_MASK = 32'((64'd1 << IDX_BITS) - 64'd1);
  localparam logic [2:0]  WAIT_CNT = 3'(WAIT_STATES);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  slave_state_t state_reg, state_next;
  logic [2:0]   cnt_reg, cnt_next;
  logic [31:0]  idx_reg, idx_next;        // captured word index
  logic         wr_reg, wr_next;          // captured direction

  logic         hreadyout_reg, hreadyout_next;
  logic         read_flag_reg, read_flag_next;
  logic         write_flag_reg, write_flag_next;
  logic [31:0]  read_addr_reg, read_addr_next;
  logic [31:0]  write_addr_reg, write_addr_next;

  // -------------------------------------------------------------------------
  // Address-phase decode
  // -------------------------------------------------------------------------
  logic        accept;
  logic [31:0] req_idx;

  // While we own a stretched data phase the bus HREADY mirrors our own
  // HREADYOUT; qualifying with our ready as well keeps the FSM from taking
  // a second transfer mid-phase if the bus mux ever glitches.
  assign accept = HSEL && HREADY && hreadyout_reg &&
                  is_active_trans(htrans_t'(HTRANS));

`ifdef ERR_RESP_EN
  logic req_err;
  logic hresp_reg, hresp_next;

  always_comb begin
    req_idx = {2'b00, HADDR[31:2]};
    req_err = (req_idx >= 32'(MEM_WORDS)) ||
              (HSIZE != HSIZE_WORD)       ||
              (HADDR[1:0] != 2'b00);
  end
`else
  // Without error responses the index simply wraps into the memory and the
  // size / byte-lane bits carry no meaning.
  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HADDR[1:0]};

  always_comb begin
    req_idx = {2'b00, HADDR[31:2]} & IDX_MASK;
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    wr_next    = wr_reg;

    case (state_reg)
      S_WAIT: begin
        // The counter holds the number of WAIT cycles still to run,
        // including this one, so a count of 1 means LAST comes next.
        if (cnt_reg <= 3'd1) begin
          state_next = S_LAST;
          cnt_next   = 3'd0;
        end else begin
          cnt_next   = cnt_reg - 3'd1;
        end
      end

`ifdef ERR_RESP_EN
      S_ERR1: begin
        state_next = S_ERR2;
        cnt_next   = 3'd0;
      end
`endif

      // IDLE, LAST and ERR2 are the cycles in which the bus is ready, so a
      // new address phase can be taken in any of them.
      default: begin
        state_next = S_IDLE;
        cnt_next   = 3'd0;
        if (accept) begin
          idx_next = req_idx;
          wr_next  = HWRITE;
`ifdef ERR_RESP_EN
          if (req_err) begin
            state_next = S_ERR1;
          end else
`endif
          if (WAIT_CNT == 3'd0) begin
            state_next = S_LAST;
          end else begin
            state_next = S_WAIT;
            cnt_next   = WAIT_CNT;
          end
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output values for the next cycle, derived from the next state so they
  // can be registered alongside it.
  // -------------------------------------------------------------------------
  logic in_phase_next;

  always_comb begin
    in_phase_next   = (state_next == S_WAIT) || (state_next == S_LAST);
    hreadyout_next  = !((state_next == S_WAIT) || (state_next == S_ERR1));
    read_flag_next  = in_phase_next && !wr_next;
    // Memory latches HWDATA on the edge that closes the data phase, so the
    // write strobe is raised only in LAST.
    write_flag_next = (state_next == S_LAST) && wr_next;
    read_addr_next  = read_flag_next ? idx_next : read_addr_reg;
    write_addr_next = (in_phase_next && wr_next) ? idx_next : write_addr_reg;
`ifdef ERR_RESP_EN
    hresp_next      = ((state_next == S_ERR1) || (state_next == S_ERR2)) ?
                      HRESP_ERROR : HRESP_OKAY;
`endif
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= 3'd0;
      idx_reg        <= 32'd0;
      wr_reg         <= 1'b0;
      hreadyout_reg  <= 1'b1;
      read_flag_reg  <= 1'b0;
      write_flag_reg <= 1'b0;
      read_addr_reg  <= 32'd0;
      write_addr_reg <= 32'd0;
`ifdef ERR_RESP_EN
      hresp_reg      <= HRESP_OKAY;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      wr_reg         <= wr_next;
      hreadyout_reg  <= hreadyout_next;
      read_flag_reg  <= read_flag_next;
      write_flag_reg <= write_flag_next;
      read_addr_reg  <= read_addr_next;
      write_addr_reg <= write_addr_next;
`ifdef ERR_RESP_EN
      hresp_reg      <= hresp_next;
`endif
    end
  end

  assign HREADYOUT  = hreadyout_reg;
  assign read_flag  = read_flag_reg;
  assign write_flag = write_flag_reg;
  assign READ_addr  = read_addr_reg;
  assign WRITE_addr = write_addr_reg;

`ifdef ERR_RESP_EN
  assign HRESP = hresp_reg;
`else
  assign HRESP = HRESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_mem_slave
//
// Two slaves (WAIT_STATES=0 and WAIT_STATES=2), each on its own bus with a
// behavioural word memory behind it. The stimulus process walks directed
// transfer tables and queues the strobe/response pattern each transfer
// must produce; a monitor pops and compares whenever a slave shows a
// strobe or an ERROR response. Idle/reset behaviour is checked directly.
// ---------------------------------------------------------------------------
module tb_ahb_lite_mem_slave;
  import ahb_lite_pkg::*;

  logic        HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        hsel0, hsel2, gate0, mem_init;

  logic        rdy0, resp0, rf0, wf0, hready0;
  logic [31:0] ra0, wa0, rdata0;
  logic        rdy2, resp2, rf2, wf2, hready2;
  logic [31:0] ra2, wa2, rdata2;

  // gate0 lets the bench pull bus HREADY low independently of the slave.
  assign hready0 = rdy0 & gate0;
  assign hready2 = rdy2;

  ahb_lite_mem_slave #(.WAIT_STATES(0), .MEM_WORDS(4096)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(hready0),
    .HREADYOUT(rdy0), .HRESP(resp0), .READ_addr(ra0), .read_flag(rf0),
    .WRITE_addr(wa0), .write_flag(wf0)
  );

  ahb_lite_mem_slave #(.WAIT_STATES(2), .MEM_WORDS(4096)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel2), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(hready2),
    .HREADYOUT(rdy2), .HRESP(resp2), .READ_addr(ra2), .read_flag(rf2),
    .WRITE_addr(wa2), .write_flag(wf2)
  );

  // Behavioural external_memory for each slave.
  logic [31:0] mem0 [0:4095];
  logic [31:0] mem2 [0:4095];

  always @(posedge HCLK) begin
    if (mem_init) begin
      for (int k = 0; k < 4096; k++) begin
        mem0[k] <= 32'h0;
        mem2[k] <= 32'h0;
      end
    end else begin
      if (wf0) mem0[wa0[11:0]] <= HWDATA;
      if (wf2) mem2[wa2[11:0]] <= HWDATA;
    end
  end

  assign rdata0 = mem0[ra0[11:0]];
  assign rdata2 = mem2[ra2[11:0]];

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic        rdy;
    logic        resp;
    logic        chk;     // compare HRDATA in this cycle
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] idx;
    logic [31:0] rdata;
  } op_t;

  exp_t q0[$];
  exp_t q2[$];
  op_t  ops[$];

  int errors = 0;
  int checks = 0;

  function automatic exp_t mk_exp(input logic rd, input logic wr,
                                  input logic [31:0] addr, input logic rdy,
                                  input logic resp, input logic chk,
                                  input logic [31:0] rdata);
    exp_t e;
    e.rd = rd; e.wr = wr; e.addr = addr; e.rdy = rdy;
    e.resp = resp; e.chk = chk; e.rdata = rdata;
    return e;
  endfunction

  task automatic check_val(input string name, input logic [31:0] got,
                           input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h required=%h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic score(input string tag, input exp_t e,
                       input logic rd, input logic wr,
                       input logic [31:0] ra, input logic [31:0] wa,
                       input logic rdy, input logic resp,
                       input logic [31:0] rdata);
    logic [31:0] got_addr;
    logic        ok;
    got_addr = rd ? ra : (wr ? wa : 32'h0);
    ok = (rd === e.rd) && (wr === e.wr) && (got_addr === e.addr) &&
         (rdy === e.rdy) && (resp === e.resp) &&
         (!e.chk || (rdata === e.rdata));
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_xfer: got rd=%b wr=%b addr=%h rdy=%b resp=%b rdata=%h required rd=%b wr=%b addr=%h rdy=%b resp=%b rdata=%h(chk=%b)",
               tag, rd, wr, got_addr, rdy, resp, rdata,
               e.rd, e.wr, e.addr, e.rdy, e.resp, e.rdata, e.chk);
    end else begin
      $display("ok   %s_xfer: rd=%b wr=%b addr=%h rdy=%b resp=%b rdata=%h",
               tag, rd, wr, got_addr, rdy, resp, rdata);
    end
  endtask

  always @(negedge HCLK) begin : monitor
    exp_t e;
    if (rf0 || wf0 || resp0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected: got rd=%b wr=%b resp=%b required no activity", rf0, wf0, resp0);
      end else begin
        e = q0.pop_front();
        score("dut0", e, rf0, wf0, ra0, wa0, rdy0, resp0, rdata0);
      end
    end
    if (rf2 || wf2 || resp2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_unexpected: got rd=%b wr=%b resp=%b required no activity", rf2, wf2, resp2);
      end else begin
        e = q2.pop_front();
        score("dut2", e, rf2, wf2, ra2, wa2, rdy2, resp2, rdata2);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HADDR  = 32'h0;
    HSIZE  = HSIZE_WORD;
  endtask

  task automatic add_op(input logic wr, input logic [31:0] haddr,
                        input logic [2:0] hsize, input logic [31:0] wdata,
                        input logic err, input logic [31:0] idx,
                        input logic [31:0] rdata);
    op_t o;
    o.wr = wr; o.haddr = haddr; o.hsize = hsize; o.wdata = wdata;
    o.err = err; o.idx = idx; o.rdata = rdata;
    ops.push_back(o);
  endtask

  task automatic push_exp(input int dut, input exp_t e);
    if (dut == 0) q0.push_back(e);
    else          q2.push_back(e);
  endtask

  // Pipelined master: the next address phase is presented during the
  // current data phase and held until the data phase ends.
  task automatic run_ops(input int dut, input int ws);
    int n;
    int ncyc;
    n = ops.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        hsel0  = (dut == 0);
        hsel2  = (dut == 2);
        HTRANS = HTRANS_NONSEQ;
        HWRITE = ops[i].wr;
        HADDR  = ops[i].haddr;
        HSIZE  = ops[i].hsize;
        if (ops[i].err) begin
          push_exp(dut, mk_exp(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0));
          push_exp(dut, mk_exp(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
        end else if (ops[i].wr) begin
          push_exp(dut, mk_exp(1'b0, 1'b1, ops[i].idx, 1'b1, 1'b0, 1'b0, 32'h0));
        end else begin
          for (int c = 0; c <= ws; c++)
            push_exp(dut, mk_exp(1'b1, 1'b0, ops[i].idx, (c == ws), 1'b0,
                                 (c == ws), ops[i].rdata));
        end
      end else begin
        bus_idle();
      end
      HWDATA = 32'h0;
      ncyc   = 1;
      if (i > 0) begin
        if (ops[i-1].wr) HWDATA = ops[i-1].wdata;
        ncyc = ops[i-1].err ? 2 : ws + 1;
      end
      repeat (ncyc) tick();
    end
    ops.delete();
  endtask

  task automatic check_quiet(input int dut, input string name,
                             input logic chk_addr);
    logic        r, p, f1, f2;
    logic [31:0] a1, a2;
    if (dut == 0) begin
      r = rdy0; p = resp0; f1 = rf0; f2 = wf0; a1 = ra0; a2 = wa0;
    end else begin
      r = rdy2; p = resp2; f1 = rf2; f2 = wf2; a1 = ra2; a2 = wa2;
    end
    check_val({name, "_hreadyout"},  32'(r),  32'd1);
    check_val({name, "_hresp"},      32'(p),  32'd0);
    check_val({name, "_read_flag"},  32'(f1), 32'd0);
    check_val({name, "_write_flag"}, 32'(f2), 32'd0);
    if (chk_addr) begin
      check_val({name, "_read_addr"},  a1, 32'd0);
      check_val({name, "_write_addr"}, a2, 32'd0);
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    HRESET   = 1'b1;
    mem_init = 1'b1;
    gate0    = 1'b1;
    HWDATA   = 32'h0;
    bus_idle();
    repeat (3) tick();
    @(negedge HCLK);
    check_quiet(0, "in_reset_dut0", 1'b1);
    check_quiet(2, "in_reset_dut2", 1'b1);
    mem_init = 1'b0;
    HRESET   = 1'b0;
    tick();
    @(negedge HCLK);
    check_quiet(0, "after_reset_dut0", 1'b1);
    check_quiet(2, "after_reset_dut2", 1'b1);

    // Zero-wait slave: back-to-back write/read pairs and the top word.
    add_op(1'b1, 32'h10,   HSIZE_WORD, 32'hDEADBEEF, 1'b0, 32'd4,     32'h0);
    add_op(1'b0, 32'h10,   HSIZE_WORD, 32'h0,        1'b0, 32'd4,     32'hDEADBEEF);
    add_op(1'b1, 32'h20,   HSIZE_WORD, 32'h12345678, 1'b0, 32'd8,     32'h0);
    add_op(1'b1, 32'h24,   HSIZE_WORD, 32'hCAFEF00D, 1'b0, 32'd9,     32'h0);
    add_op(1'b0, 32'h24,   HSIZE_WORD, 32'h0,        1'b0, 32'd9,     32'hCAFEF00D);
    add_op(1'b0, 32'h20,   HSIZE_WORD, 32'h0,        1'b0, 32'd8,     32'h12345678);
    add_op(1'b1, 32'h3FFC, HSIZE_WORD, 32'hA5A5A5A5, 1'b0, 32'h0FFF,  32'h0);
    add_op(1'b0, 32'h3FFC, HSIZE_WORD, 32'h0,        1'b0, 32'h0FFF,  32'hA5A5A5A5);
    run_ops(0, 0);

    // Two-wait slave: HREADYOUT 0,0,1 and read_flag held across the phase.
    add_op(1'b1, 32'h8, HSIZE_WORD, 32'h0BADF00D, 1'b0, 32'd2, 32'h0);
    add_op(1'b0, 32'h8, HSIZE_WORD, 32'h0,        1'b0, 32'd2, 32'h0BADF00D);
    add_op(1'b1, 32'hC, HSIZE_WORD, 32'h13579BDF, 1'b0, 32'd3, 32'h0);
    add_op(1'b0, 32'hC, HSIZE_WORD, 32'h0,        1'b0, 32'd3, 32'h13579BDF);
    run_ops(2, 2);

    // Transfers that must not start a data phase.
    hsel0 = 1'b1; HTRANS = HTRANS_BUSY; HWRITE = 1'b1; HADDR = 32'h10;
    tick();
    @(negedge HCLK);
    check_quiet(0, "busy", 1'b0);
    hsel0 = 1'b0; HTRANS = HTRANS_NONSEQ;
    tick();
    @(negedge HCLK);
    check_quiet(0, "hsel_low", 1'b0);
    hsel0 = 1'b1; gate0 = 1'b0;
    tick();
    @(negedge HCLK);
    check_quiet(0, "hready_low", 1'b0);
    bus_idle();
    gate0 = 1'b1;
    tick();

    // Out-of-range, misaligned and non-word transfers.
`ifdef ERR_RESP_EN
    add_op(1'b1, 32'h4000, HSIZE_WORD, 32'h77777777, 1'b1, 32'h0, 32'h0);
    add_op(1'b0, 32'h0,    HSIZE_WORD, 32'h0,        1'b0, 32'h0, 32'h0);
    add_op(1'b0, 32'h2,    HSIZE_WORD, 32'h0,        1'b1, 32'h0, 32'h0);
    add_op(1'b1, 32'h0,    3'b001,     32'h00000055, 1'b1, 32'h0, 32'h0);
    add_op(1'b0, 32'h0,    HSIZE_WORD, 32'h0,        1'b0, 32'h0, 32'h0);
`else
    add_op(1'b1, 32'h4000, HSIZE_WORD, 32'h77777777, 1'b0, 32'h0, 32'h0);
    add_op(1'b0, 32'h0,    HSIZE_WORD, 32'h0,        1'b0, 32'h0, 32'h77777777);
    add_op(1'b0, 32'h2,    HSIZE_WORD, 32'h0,        1'b0, 32'h0, 32'h77777777);
    add_op(1'b1, 32'h4,    3'b001,     32'h00000055, 1'b0, 32'h1, 32'h0);
    add_op(1'b0, 32'h4,    HSIZE_WORD, 32'h0,        1'b0, 32'h1, 32'h00000055);
`endif
    run_ops(0, 0);

    // Reset during the WAIT cycle of a write aborts it without a commit.
    hsel2 = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h14;
    HSIZE = HSIZE_WORD;
    tick();
    bus_idle();
    HWDATA = 32'hFFFFFFFF;
    HRESET = 1'b1;
    tick();
    @(negedge HCLK);
    check_quiet(2, "abort_dut2", 1'b1);
    check_quiet(0, "abort_dut0", 1'b0);
    HRESET = 1'b0;
    HWDATA = 32'h0;
    tick();
    tick();
    add_op(1'b0, 32'h14, HSIZE_WORD, 32'h0, 1'b0, 32'd5, 32'h0);
    run_ops(2, 2);

    repeat (3) tick();
    check_val("dut0_pending_expected", 32'(q0.size()), 32'd0);
    check_val("dut2_pending_expected", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
